countdown_timer: RTL and testbench

//  Loadable down-counter that consumes single-cycle tick enables (e.g. the terminal-count

---
 rtl/timer_pkg.sv | 12 +
 rtl/countdown_timer.sv | 111 +++++++++++
 tb/tb_countdown_timer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared state encoding for the countdown timer.
package timer_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

endpackage : timer_pkg

// File: rtl/countdown_timer.sv
// Loadable down-counter driven by single-cycle tick enables, with a one-cycle
// done pulse on expiry and optional auto-reload from the last loaded value.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned INIT   = (1 << N) - 1,
  parameter bit          RELOAD = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] D,
  input  logic         start,
  input  logic         pause,
  input  logic         tick,
  output logic [N-1:0] C,
  output logic         Z,
  output logic         done,
  output logic         busy
);

  localparam logic [N-1:0] INIT_V = N'(INIT);
  localparam logic [N-1:0] ONE_V  = N'(1);

  state_t       state;
  state_t       state_nxt;
  logic [N-1:0] r_q;
  logic [N-1:0] c_nxt;
  logic [N-1:0] r_nxt;
  logic         done_nxt;

  // State, count, reload value and done pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      C     <= INIT_V;
      r_q   <= INIT_V;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      C     <= c_nxt;
      r_q   <= r_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state logic; priority is load > start > tick, pause gates ticks in RUN
  always_comb begin
    state_nxt = state;
    c_nxt     = C;
    r_nxt     = r_q;
    done_nxt  = 1'b0;

    if (load) begin
      c_nxt     = D;
      r_nxt     = D;
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (C != '0) begin
              state_nxt = ST_RUN;
            end else begin
              state_nxt = ST_EXPIRED;
              done_nxt  = 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (tick && !pause) begin
            if (C > ONE_V) begin
              c_nxt = C - ONE_V;
            end else if (C == ONE_V) begin
              done_nxt = 1'b1;
              if (RELOAD) begin
                // Reload of a zero value cannot keep running
                c_nxt     = r_q;
                state_nxt = (r_q == '0) ? ST_EXPIRED : ST_RUN;
              end else begin
                c_nxt     = '0;
                state_nxt = ST_EXPIRED;
              end
            end
          end
        end

        ST_EXPIRED: begin
          if (start) begin
            c_nxt = r_q;
            if (r_q != '0) begin
              state_nxt = ST_RUN;
            end else begin
              done_nxt = 1'b1;
            end
          end
        end

        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign Z    = (C == '0);
  assign busy = (state == ST_RUN);

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Directed and randomized checks of countdown_timer (one-shot and auto-reload
// instances side by side) against a behavioural model of the timer rules.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] d = '0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       tick = 1'b0;

  logic [3:0] c_o    [2];
  logic       z_o    [2];
  logic       done_o [2];
  logic       busy_o [2];

  int checks   = 0;
  int failures = 0;

  // Model: mode 0 = waiting, 1 = counting, 2 = expired
  int mc [2];
  int mr [2];
  int mm [2];
  int md [2];

  always #5 clk = ~clk;

  countdown_timer #(.N(4), .RELOAD(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .load(load), .D(d), .start(start),
    .pause(pause), .tick(tick), .C(c_o[0]), .Z(z_o[0]), .done(done_o[0]),
    .busy(busy_o[0])
  );

  countdown_timer #(.N(4), .RELOAD(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .D(d), .start(start),
    .pause(pause), .tick(tick), .C(c_o[1]), .Z(z_o[1]), .done(done_o[1]),
    .busy(busy_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mc[k] = 15; mr[k] = 15; mm[k] = 0; md[k] = 0;
    end
  endtask

  // One clock edge of the timer rules for instance k (k==1 is auto-reload)
  task automatic model_step(input int k);
    md[k] = 0;
    if (load) begin
      mc[k] = int'(d); mr[k] = int'(d); mm[k] = 0;
    end else if (mm[k] == 0) begin
      if (start) begin
        if (mc[k] != 0) mm[k] = 1;
        else begin mm[k] = 2; md[k] = 1; end
      end
    end else if (mm[k] == 1) begin
      if (tick && !pause) begin
        if (mc[k] > 1) mc[k] = mc[k] - 1;
        else if (mc[k] == 1) begin
          md[k] = 1;
          if (k == 1) begin
            mc[k] = mr[k];
            if (mr[k] == 0) mm[k] = 2;
          end else begin
            mc[k] = 0; mm[k] = 2;
          end
        end
      end
    end else begin
      if (start) begin
        mc[k] = mr[k];
        if (mr[k] != 0) mm[k] = 1;
        else md[k] = 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_C%0d", tag, k), 32'(c_o[k]), 32'(mc[k]));
      chk($sformatf("%s_Z%0d", tag, k), 32'(z_o[k]), 32'(mc[k] == 0));
      chk($sformatf("%s_done%0d", tag, k), 32'(done_o[k]), 32'(md[k]));
      chk($sformatf("%s_busy%0d", tag, k), 32'(busy_o[k]), 32'(mm[k] == 1));
    end
  endtask

  task automatic step(input string tag, input logic l, input logic [3:0] dv,
                      input logic s, input logic p, input logic t);
    @(negedge clk);
    load = l; d = dv; start = s; pause = p; tick = t;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    compare_all("reset");
    chk("reset_C_const", 32'(c_o[0]), 32'd15);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: one-shot countdown from 3
    step("t1_load", 1, 4'd3, 0, 0, 0);
    step("t1_start", 0, 4'd0, 1, 0, 0);
    step("t1_tick1", 0, 4'd0, 0, 0, 1);
    step("t1_tick2", 0, 4'd0, 0, 0, 1);
    step("t1_tick3", 0, 4'd0, 0, 0, 1);
    chk("t1_C_zero", 32'(c_o[0]), 32'd0);
    chk("t1_done", 32'(done_o[0]), 32'd1);
    chk("t1_busy", 32'(busy_o[0]), 32'd0);
    step("t1_after", 0, 4'd0, 0, 0, 1);
    chk("t1_done_once", 32'(done_o[0]), 32'd0);

    // 2: auto-reload from 2 over five ticks
    step("t2_load", 1, 4'd2, 0, 0, 0);
    step("t2_start", 0, 4'd0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step($sformatf("t2_tick%0d", i), 0, 4'd0, 0, 0, 1);
    chk("t2_C_final", 32'(c_o[1]), 32'd1);

    // 3: pause holds the count
    step("t3_load", 1, 4'd5, 0, 0, 0);
    step("t3_start", 0, 4'd0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step($sformatf("t3_pause%0d", i), 0, 4'd0, 0, 1, 1);
    step("t3_tick", 0, 4'd0, 0, 0, 1);
    chk("t3_C", 32'(c_o[0]), 32'd4);

    // 4: load with tick aborts a running count
    step("t4_load", 1, 4'd3, 0, 0, 0);
    step("t4_start", 0, 4'd0, 1, 0, 1);
    step("t4_tick", 0, 4'd0, 0, 0, 1);
    step("t4_abort", 1, 4'd9, 0, 1, 1);
    chk("t4_C", 32'(c_o[0]), 32'd9);
    step("t4_start2", 0, 4'd0, 1, 0, 0);
    step("t4_tick2", 0, 4'd0, 0, 0, 1);
    chk("t4_C2", 32'(c_o[0]), 32'd8);

    // 5: start with a zero count expires immediately
    step("t5_load", 1, 4'd0, 0, 0, 0);
    step("t5_start", 0, 4'd0, 1, 0, 0);
    chk("t5_done", 32'(done_o[0]), 32'd1);
    step("t5_tick1", 0, 4'd0, 0, 0, 1);
    step("t5_tick2", 0, 4'd0, 0, 0, 1);
    chk("t5_quiet", 32'(done_o[0]), 32'd0);

    // 6: asynchronous reset mid-count
    step("t6_load", 1, 4'd7, 0, 0, 0);
    step("t6_start", 0, 4'd0, 1, 0, 0);
    @(negedge clk);
    load = 0; start = 0; pause = 0; tick = 1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("t6_idle%0d", i), 0, 4'd0, 0, 0, 1);
    chk("t6_C_held", 32'(c_o[0]), 32'd15);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic       l, s, p, t;
      logic [3:0] dv;
      l  = ($urandom_range(0, 15) == 0);
      s  = ($urandom_range(0, 5) == 0);
      p  = ($urandom_range(0, 3) == 0);
      t  = ($urandom_range(0, 1) == 1);
      dv = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15));
      step($sformatf("rnd%0d", i), l, dv, s, p, t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_countdown_timer
